snn_output_decoder: RTL and testbench
=====================================

# snn_output_decoder

Output stage of the MNIST spiking network: accumulates the per-timestep spike vector emitted by the output neuron layer over one inference window, then scans the per-class spike counts sequentially and reports the winning digit. Sits directly downstream of the `snn` core and produces its 4-bit classification `result`. Replaces ad-hoc argmax logic with a counted, saturating, handshaked decoder.

## Interface
- `NUM_CLASSES`, 10, number of output neurons/classes (≤16)
- `CNT_WIDTH`, 7, width of each per-class spike counter
- `TIMESTEP_MAX`, 200, maximum accepted timesteps per inference
- `clk` input 1 — system clock, all logic on rising edge
- `rstn` input 1 — reset, asynchronous, active-low
- `start` input 1 — single-cycle pulse: clear counters, begin new inference
- `spike_valid` input 1 — `spikes` holds one timestep's output spikes
- `spikes` input NUM_CLASSES — bit i = output neuron i fired this timestep
- `spike_last` input 1 — qualifies `spike_valid`: this is the final timestep
- `busy` output 1 — high in ACCUM or SCAN
- `result` output 4 — winning class index
- `result_valid` output 1 — `result`/`result_none` valid; level, held until next `start`
- `result_none` output 1 — all class counts were zero

## Operation
- Reset (async assert): state IDLE; all counters, timestep counter, `result`, `result_valid`, `result_none`, `busy` = 0.
- States: IDLE, ACCUM, SCAN, DONE.
- IDLE: `spike_valid` ignored. `start` → clear counters and timestep count, go ACCUM.
- ACCUM: on each `spike_valid` beat, for every i with `spikes[i]`=1, `cnt[i] <= cnt[i]+1`, saturating at 2^CNT_WIDTH−1 (127; never wraps). Timestep counter (width $clog2(TIMESTEP_MAX+1)) increments per beat. Transition to SCAN on a beat with `spike_last`=1, or on the beat that makes timestep count == TIMESTEP_MAX; that beat's spikes are counted. `spike_valid`=0 cycles are idle; no timeout.
- SCAN: index k walks 0..NUM_CLASSES−1, one class per cycle. `best` starts at cnt[0]/index 0; later class replaces best only if strictly greater, so ties resolve to the lowest index. After k = NUM_CLASSES−1: register `result` = best index, `result_none` = (best count == 0), `result_valid` = 1, go DONE. `spike_valid` during SCAN ignored.
- DONE: outputs held. `spike_valid` ignored. `start` → ACCUM as from IDLE.
- `start` in any state, including mid-ACCUM or mid-SCAN: abort, clear counters, timestep count, `result_valid`, `result_none`; go ACCUM. `result` keeps old value but is invalid.
- `start` and `spike_valid` in same cycle: spike beat discarded (counters cleared, not incremented).
- `rstn` deasserted mid-inference: immediate return to reset values; no partial result.

## Timing
- `busy` rises the cycle after `start` is sampled, falls with `result_valid` rising.
- Result latency: `result_valid` rises exactly NUM_CLASSES clock edges after the edge that samples the final beat (10 cycles at defaults).
- `result_valid` falls the cycle after `start` is sampled.
- One spike beat accepted per cycle in ACCUM; back-to-back beats at full rate required.
- Counter update and timestep count update in the same edge as beat acceptance; no backpressure output (upstream must not send beats outside ACCUM).

## Test plan
- Reset then `start`, 200 beats with only class 7 spiking every beat, no `spike_last` → auto-stop at beat 200, cnt[7] saturates at 127, `result`=7, `result_valid` 10 cycles after beat 200, `result_none`=0.
- `start`, 5 beats: class 3 fires 3×, class 5 fires 3×, class 1 fires 2×, last beat with `spike_last` → `result`=3 (tie, lowest index), exactly 10 cycles latency.
- `start`, 4 beats all-zero `spikes`, `spike_last` on 4th → `result`=0, `result_none`=1, `result_valid`=1.
- `start`, 50 beats class 2, then `start` again with simultaneous `spike_valid` on class 9, then 3 beats class 4 + `spike_last` → `result`=4, cnt[2]=0, cnt[9]=0; `result_valid` low from cycle after second `start` until done.
- Assert `rstn`=0 asynchronously during SCAN → all outputs 0 immediately, state IDLE; subsequent `spike_valid` ignored until `start`.
- Beats with gaps (`spike_valid` toggling) and `spike_valid` during SCAN/DONE → only ACCUM beats counted; `result` matches model argmax.

Source files
------------

// File: rtl/snn_output_decoder.sv
// snn_output_decoder: accumulates per-timestep output spikes over one inference
// window into saturating per-class counters, then scans the counters one class
// per cycle and reports the winning class (lowest index wins ties).
module snn_output_decoder #(
   parameter int NUM_CLASSES  = 10,
   parameter int CNT_WIDTH    = 7,
   parameter int TIMESTEP_MAX = 200
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic                   start,
   input  logic                   spike_valid,
   input  logic [NUM_CLASSES-1:0] spikes,
   input  logic                   spike_last,
   output logic                   busy,
   output logic [3:0]             result,
   output logic                   result_valid,
   output logic                   result_none
);

   localparam int TS_W  = $clog2(TIMESTEP_MAX + 1);
   localparam int IDX_W = 4;
   localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};
   localparam logic [TS_W-1:0]      TS_LIMIT = TS_W'(TIMESTEP_MAX);
   localparam logic [IDX_W-1:0]     K_LAST   = IDX_W'(NUM_CLASSES - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_SCAN  = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   state_t                 state_q, state_d;
   logic [CNT_WIDTH-1:0]   cnt_q [NUM_CLASSES];
   logic [CNT_WIDTH-1:0]   cnt_d [NUM_CLASSES];
   logic [TS_W-1:0]        ts_q, ts_d;
   logic [IDX_W-1:0]       k_q, k_d;
   logic [CNT_WIDTH-1:0]   best_cnt_q, best_cnt_d;
   logic [IDX_W-1:0]       best_idx_q, best_idx_d;
   logic [3:0]             result_q, result_d;
   logic                   result_valid_q, result_valid_d;
   logic                   result_none_q, result_none_d;
   logic                   busy_q, busy_d;

   logic [CNT_WIDTH-1:0]   cand_cnt_s;
   logic [CNT_WIDTH-1:0]   scan_cnt_s;
   logic [IDX_W-1:0]       scan_idx_s;
   logic [TS_W-1:0]        ts_inc_s;

   // Select the counter under scan and fold it into the running best (strictly greater replaces).
   always_comb begin
      cand_cnt_s = {CNT_WIDTH{1'b0}};
      for (int i = 0; i < NUM_CLASSES; i++) begin
         if (IDX_W'(i) == k_q) begin
            cand_cnt_s = cnt_q[i];
         end else begin
            cand_cnt_s = cand_cnt_s;
         end
      end
      if (k_q == {IDX_W{1'b0}}) begin
         scan_cnt_s = cand_cnt_s;
         scan_idx_s = {IDX_W{1'b0}};
      end else if (cand_cnt_s > best_cnt_q) begin
         scan_cnt_s = cand_cnt_s;
         scan_idx_s = k_q;
      end else begin
         scan_cnt_s = best_cnt_q;
         scan_idx_s = best_idx_q;
      end
   end

   // Next-state and datapath update; start aborts anything and discards a coincident beat.
   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      ts_d           = ts_q;
      k_d            = k_q;
      best_cnt_d     = best_cnt_q;
      best_idx_d     = best_idx_q;
      result_d       = result_q;
      result_valid_d = result_valid_q;
      result_none_d  = result_none_q;
      busy_d         = busy_q;
      ts_inc_s       = ts_q + TS_W'(1);

      if (start) begin
         for (int i = 0; i < NUM_CLASSES; i++) begin
            cnt_d[i] = {CNT_WIDTH{1'b0}};
         end
         ts_d           = {TS_W{1'b0}};
         k_d            = {IDX_W{1'b0}};
         result_valid_d = 1'b0;
         result_none_d  = 1'b0;
         busy_d         = 1'b1;
         state_d        = ST_ACCUM;
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_d = ST_IDLE;
            end
            ST_ACCUM: begin
               if (spike_valid) begin
                  for (int i = 0; i < NUM_CLASSES; i++) begin
                     if (spikes[i] && (cnt_q[i] != CNT_MAX)) begin
                        cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
                     end else begin
                        cnt_d[i] = cnt_q[i];
                     end
                  end
                  ts_d = ts_inc_s;
                  if (spike_last || (ts_inc_s == TS_LIMIT)) begin
                     k_d     = {IDX_W{1'b0}};
                     state_d = ST_SCAN;
                  end else begin
                     state_d = ST_ACCUM;
                  end
               end else begin
                  state_d = ST_ACCUM;
               end
            end
            ST_SCAN: begin
               best_cnt_d = scan_cnt_s;
               best_idx_d = scan_idx_s;
               if (k_q == K_LAST) begin
                  result_d       = scan_idx_s;
                  result_none_d  = (scan_cnt_s == {CNT_WIDTH{1'b0}});
                  result_valid_d = 1'b1;
                  busy_d         = 1'b0;
                  state_d        = ST_DONE;
               end else begin
                  k_d     = k_q + IDX_W'(1);
                  state_d = ST_SCAN;
               end
            end
            ST_DONE: begin
               state_d = ST_DONE;
            end
            default: begin
               busy_d  = 1'b0;
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // State and datapath registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= ST_IDLE;
         for (int i = 0; i < NUM_CLASSES; i++) begin
            cnt_q[i] <= {CNT_WIDTH{1'b0}};
         end
         ts_q           <= {TS_W{1'b0}};
         k_q            <= {IDX_W{1'b0}};
         best_cnt_q     <= {CNT_WIDTH{1'b0}};
         best_idx_q     <= {IDX_W{1'b0}};
         result_q       <= 4'd0;
         result_valid_q <= 1'b0;
         result_none_q  <= 1'b0;
         busy_q         <= 1'b0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         ts_q           <= ts_d;
         k_q            <= k_d;
         best_cnt_q     <= best_cnt_d;
         best_idx_q     <= best_idx_d;
         result_q       <= result_d;
         result_valid_q <= result_valid_d;
         result_none_q  <= result_none_d;
         busy_q         <= busy_d;
      end
   end

   assign busy         = busy_q;
   assign result       = result_q;
   assign result_valid = result_valid_q;
   assign result_none  = result_none_q;

endmodule

// File: tb/tb_snn_output_decoder.sv
// Self-checking bench for snn_output_decoder: a behavioural model pushes the
// expected result to a scoreboard when the final beat is driven; the entry is
// popped and compared when result_valid rises, together with the latency.
module tb_snn_output_decoder;

   localparam int NC = 10;

   logic          clk;
   logic          rstn;
   logic          start;
   logic          spike_valid;
   logic [NC-1:0] spikes;
   logic          spike_last;
   logic          busy;
   logic [3:0]    result;
   logic          result_valid;
   logic          result_none;

   typedef struct {
      logic [3:0] res;
      logic       none;
   } exp_t;

   exp_t sb_q[$];
   exp_t last_exp;
   int   m_cnt[NC];
   int   m_ts;
   bit   m_accum;
   int   n_checks;
   int   n_pass;

   snn_output_decoder #(.NUM_CLASSES(NC), .CNT_WIDTH(7), .TIMESTEP_MAX(200)) dut (
      .clk          (clk),
      .rstn         (rstn),
      .start        (start),
      .spike_valid  (spike_valid),
      .spikes       (spikes),
      .spike_last   (spike_last),
      .busy         (busy),
      .result       (result),
      .result_valid (result_valid),
      .result_none  (result_none)
   );

   // Free-running 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < NC; i++) m_cnt[i] = 0;
      m_ts    = 0;
      m_accum = 1'b1;
      sb_q.delete();
   endtask

   task automatic model_push();
      int   best;
      int   idx;
      exp_t e;
      best = m_cnt[0];
      idx  = 0;
      for (int i = 1; i < NC; i++) begin
         if (m_cnt[i] > best) begin
            best = m_cnt[i];
            idx  = i;
         end
      end
      e.res  = 4'(idx);
      e.none = (best == 0);
      sb_q.push_back(e);
   endtask

   task automatic do_start();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      model_clear();
   endtask

   // Start pulse coinciding with a spike beat: the beat must be discarded.
   task automatic start_with_beat(input logic [NC-1:0] s);
      start       = 1'b1;
      spike_valid = 1'b1;
      spikes      = s;
      @(posedge clk); #1;
      start       = 1'b0;
      spike_valid = 1'b0;
      spikes      = '0;
      model_clear();
   endtask

   task automatic beat(input logic [NC-1:0] s, input logic last);
      spike_valid = 1'b1;
      spikes      = s;
      spike_last  = last;
      if (m_accum) begin
         for (int i = 0; i < NC; i++) begin
            if (s[i] && m_cnt[i] < 127) m_cnt[i]++;
         end
         m_ts++;
         if (last || m_ts == 200) begin
            model_push();
            m_accum = 1'b0;
         end
      end
      @(posedge clk); #1;
      spike_valid = 1'b0;
      spikes      = '0;
      spike_last  = 1'b0;
   endtask

   task automatic idle_cycle();
      @(posedge clk); #1;
   endtask

   // Wait (bounded) for result_valid after the final beat; optionally drive noise beats during SCAN.
   task automatic wait_result(input bit noise, input string tag);
      int   n;
      bit   busy_bad;
      exp_t e;
      n        = 0;
      busy_bad = 1'b0;
      while (!result_valid && n < 40) begin
         if (noise) begin
            spike_valid = 1'b1;
            spikes      = NC'($urandom);
            spike_last  = 1'($urandom);
         end
         @(posedge clk); #1;
         n++;
         if (!result_valid && !busy) busy_bad = 1'b1;
      end
      spike_valid = 1'b0;
      spikes      = '0;
      spike_last  = 1'b0;
      check_val({tag, "_latency"}, n, 10);
      check_val({tag, "_busy_scan"}, busy_bad, 0);
      check_val({tag, "_busy_done"}, busy, 0);
      if (sb_q.size() == 0) begin
         check_val({tag, "_sb_entry"}, 0, 1);
      end else begin
         e        = sb_q.pop_front();
         last_exp = e;
         check_val({tag, "_result"}, result, e.res);
         check_val({tag, "_none"}, result_none, e.none);
      end
   endtask

   // Stimulus sequence.
   initial begin
      logic [NC-1:0] s;
      n_checks    = 0;
      n_pass      = 0;
      m_accum     = 1'b0;
      rstn        = 1'b1;
      start       = 1'b0;
      spike_valid = 1'b0;
      spikes      = '0;
      spike_last  = 1'b0;
      #2 rstn = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_val("rst_busy", busy, 0);
      check_val("rst_valid", result_valid, 0);
      check_val("rst_result", result, 0);
      check_val("rst_none", result_none, 0);
      @(negedge clk) rstn = 1'b1;
      idle_cycle();

      // Class 7 every beat, auto-stop at 200 timesteps.
      do_start();
      check_val("t1_start_busy", busy, 1);
      check_val("t1_start_valid", result_valid, 0);
      for (int b = 0; b < 200; b++) beat(10'b0010000000, 1'b0);
      wait_result(1'b0, "t1");

      // Classes 2 and 7 both saturate at 127: tie goes to class 2.
      do_start();
      check_val("t1b_valid_drop", result_valid, 0);
      for (int b = 0; b < 200; b++) begin
         s = 10'b0010000000;
         if (b < 130) s[2] = 1'b1;
         beat(s, 1'b0);
      end
      wait_result(1'b0, "t1b");

      // Tie between classes 3 and 5 resolves to 3.
      do_start();
      beat(10'b0000101010, 1'b0);
      beat(10'b0000101010, 1'b0);
      beat(10'b0000101000, 1'b0);
      beat(10'b0000000000, 1'b0);
      beat(10'b0000000000, 1'b1);
      wait_result(1'b0, "t2");

      // All-zero spikes: result_none.
      do_start();
      for (int b = 0; b < 4; b++) beat('0, (b == 3));
      wait_result(1'b0, "t3");

      // Abort with a coincident beat on class 9.
      do_start();
      for (int b = 0; b < 50; b++) beat(10'b0000000100, 1'b0);
      start_with_beat(10'b1000000000);
      check_val("t4_restart_valid", result_valid, 0);
      check_val("t4_restart_busy", busy, 1);
      for (int b = 0; b < 3; b++) beat(10'b0000010000, (b == 2));
      wait_result(1'b0, "t4");

      // Coincident beat on class 0 must not tie with a single class 5 beat.
      start_with_beat(10'b0000000001);
      beat(10'b0000100000, 1'b1);
      wait_result(1'b0, "t4b");

      // Asynchronous reset during SCAN.
      do_start();
      for (int b = 0; b < 3; b++) beat(10'b0001000000, (b == 2));
      repeat (3) @(posedge clk);
      #3 rstn = 1'b0;
      #1;
      check_val("t5_rst_busy", busy, 0);
      check_val("t5_rst_valid", result_valid, 0);
      check_val("t5_rst_result", result, 0);
      check_val("t5_rst_none", result_none, 0);
      sb_q.delete();
      m_accum = 1'b0;
      @(negedge clk) rstn = 1'b1;
      for (int b = 0; b < 3; b++) beat(10'b0100000000, (b == 2));
      repeat (12) idle_cycle();
      check_val("t5_idle_valid", result_valid, 0);
      check_val("t5_idle_busy", busy, 0);

      // Gapped random beats, noise during SCAN and DONE.
      for (int r = 0; r < 3; r++) begin
         do_start();
         for (int b = 0; b < 30; b++) begin
            if ($urandom_range(2, 0) == 0) idle_cycle();
            else beat(NC'($urandom), 1'b0);
         end
         beat(NC'($urandom), 1'b1);
         wait_result(1'b1, "t6");
         for (int b = 0; b < 5; b++) beat(NC'($urandom), 1'($urandom));
         check_val("t6_done_valid", result_valid, 1);
         check_val("t6_done_result", result, last_exp.res);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
